// File: rtl/latch_wr_sched.sv
// Write scheduler for a transparent-latch bank: arbitrates requesters, then runs one gate through SETUP/OPEN/CLOSE.
// Define LWS_FIXED_PRIO_EN for fixed lowest-index-first priority; the default is round-robin.
module latch_wr_sched #(
  parameter int N_REQ    = 4,
  parameter int N_LAT    = 4,
  parameter int WIDTH    = 8,
  parameter int OPEN_CYC = 2,
  parameter int AW       = (N_LAT > 1) ? $clog2(N_LAT) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*AW-1:0]    addr_i,
  input  logic [N_REQ*WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [WIDTH-1:0]       lat_d_o,
  output logic [N_LAT-1:0]       lat_en_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_CLOSE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [WIDTH-1:0]   lat_d_q, lat_d_d;
  logic [N_LAT-1:0]   lat_en_q, lat_en_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic               any_req;
  logic [PW-1:0]      win_idx;
  logic [AW-1:0]      win_addr;
  logic [WIDTH-1:0]   win_data;
  logic [N_LAT-1:0]   sel_en;
  logic               addr_oor;

`ifdef LWS_FIXED_PRIO_EN
  always_comb begin
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) win_idx = PW'(i);
    end
  end
`else
  logic [PW-1:0] ptr_q;
  logic          found;
  int            rr_idx;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    rr_idx  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_idx = (int'(ptr_q) + 1 + i) % N_REQ;
      if (!found && req_i[rr_idx]) begin
        found   = 1'b1;
        win_idx = PW'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= PW'(N_REQ - 1);
    end else if (|gnt_d) begin
      ptr_q <= win_idx;
    end
  end
`endif

  always_comb begin
    any_req  = |req_i;
    win_addr = addr_i[win_idx*AW +: AW];
    win_data = data_i[win_idx*WIDTH +: WIDTH];
    addr_oor = ({1'b0, addr_q} >= (AW+1)'(N_LAT));
    sel_en   = '0;
    for (int j = 0; j < N_LAT; j++) begin
      sel_en[j] = (addr_q == AW'(j));
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    lat_d_d  = lat_d_q;
    lat_en_d = '0;
    gnt_d    = '0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE, S_CLOSE: begin
        if (any_req) begin
          state_d        = S_SETUP;
          gnt_d[win_idx] = 1'b1;
          addr_d         = win_addr;
          lat_d_d        = win_data;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d  = S_OPEN;
        cnt_d    = CW'(OPEN_CYC - 1);
        lat_en_d = sel_en;
        err_d    = addr_oor;
      end
      S_OPEN: begin
        // Counter reaching zero means the gate has been open OPEN_CYC cycles.
        if (cnt_q == '0) begin
          state_d = S_CLOSE;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          lat_en_d = sel_en;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign lat_d_o  = lat_d_q;
  assign lat_en_o = lat_en_q;
  assign busy_o   = busy_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_latch_wr_sched.sv
// Directed bench for latch_wr_sched: default bank plus a 3-word bank for out-of-range addresses.
module tb_latch_wr_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  addr;
  logic [31:0] data;

  logic [3:0]  gnt, gnt3;
  logic [7:0]  lat_d, lat_d3;
  logic [3:0]  lat_en;
  logic [2:0]  lat_en3;
  logic        busy, busy3, err, err3;

  int checks = 0;
  int failures = 0;

  latch_wr_sched u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .data_i(data),
    .gnt_o(gnt), .lat_d_o(lat_d), .lat_en_o(lat_en), .busy_o(busy), .err_o(err)
  );

  latch_wr_sched #(.N_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .data_i(data),
    .gnt_o(gnt3), .lat_d_o(lat_d3), .lat_en_o(lat_en3), .busy_o(busy3), .err_o(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rq(input int k, input logic [1:0] a, input logic [7:0] d);
    addr[k*2 +: 2] = a;
    data[k*8 +: 8] = d;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && busy; i++) cyc();
    check(tag, busy, 1'b0);
  endtask

  int order[4];
  int n;
  int last;

  initial begin
    rst = 1'b1; req = '0; addr = '0; data = '0;
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;
    check("rst_gnt", gnt, 4'b0);
    check("rst_en", lat_en, 4'b0);
    check("rst_d", lat_d, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);

    // Single write: requester 0, address 2, data A5.
    set_rq(0, 2'd2, 8'hA5); req = 4'b0001;
    cyc();
    check("sw_gnt", gnt, 4'b0001);
    check("sw_d", lat_d, 8'hA5);
    check("sw_en_setup", lat_en, 4'b0000);
    check("sw_busy", busy, 1'b1);
    req = 4'b0000;
    cyc();
    check("sw_gnt_pulse", gnt, 4'b0000);
    check("sw_en_open1", lat_en, 4'b0100);
    cyc();
    check("sw_en_open2", lat_en, 4'b0100);
    cyc();
    check("sw_en_close", lat_en, 4'b0000);
    check("sw_busy_close", busy, 1'b1);
    check("sw_d_hold", lat_d, 8'hA5);
    cyc();
    check("sw_idle", busy, 1'b0);
    check("sw_d_idle", lat_d, 8'hA5);

    // Reset held 3 cycles while the gate is open.
    set_rq(0, 2'd1, 8'h3C); req = 4'b0001;
    cyc();
    req = 4'b0000;
    cyc();
    check("mr_open", lat_en, 4'b0010);
    rst = 1'b1;
    cyc();
    check("mr_en", lat_en, 4'b0);
    check("mr_d", lat_d, 8'h00);
    check("mr_gnt", gnt, 4'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_err", err, 1'b0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    check("mr_after_busy", busy, 1'b0);
    check("mr_after_gnt", gnt, 4'b0);

    // Contention: all four request; pointer was reset so requester 0 goes first.
`ifdef LWS_FIXED_PRIO_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3};
`endif
    for (int k = 0; k < 4; k++) set_rq(k, 2'(k), 8'(8'h10 + k));
    req = 4'b1111; n = 0; last = -10;
    for (int c = 1; c <= 24 && n < 4; c++) begin
      cyc();
      check("ct_onehot0", 32'($onehot0(lat_en)), 1);
      if (c == last + 1) check("ct_en", lat_en, 4'b1 << order[n-1]);
      if (gnt != 4'b0) begin
        check("ct_gnt", gnt, 4'b1 << order[n]);
        check("ct_d", lat_d, 8'h10 + order[n]);
        if (n > 0) check("ct_gap", c - last, 4);
        last = c;
        n++;
`ifdef LWS_FIXED_PRIO_EN
        req = (req & ~gnt) | 4'b0001;
`else
        req = req & ~gnt;
`endif
      end
    end
    check("ct_count", n, 4);
    req = 4'b0000;
    drain("ct_drain");

    // Fairness: requesters 1 and 3 keep requesting.
`ifdef LWS_FIXED_PRIO_EN
    order = '{1, 1, 1, 1};
`else
    order = '{1, 3, 1, 3};
`endif
    req = 4'b1010; n = 0;
    for (int c = 1; c <= 24 && n < 4; c++) begin
      cyc();
      if (gnt != 4'b0) begin
        check("fa_gnt", gnt, 4'b1 << order[n]);
        n++;
      end
    end
    check("fa_count", n, 4);
    req = 4'b0000;
    drain("fa_drain");

    // Back-to-back: requester 2 arrives while requester 0's gate is open.
    set_rq(0, 2'd0, 8'h11); req = 4'b0001;
    cyc();
    check("bb_gnt0", gnt, 4'b0001);
    req = 4'b0000;
    cyc();
    check("bb_open0", lat_en, 4'b0001);
    set_rq(2, 2'd3, 8'hCC); req = 4'b0100;
    cyc();
    check("bb_gnt_none", gnt, 4'b0000);
    cyc();
    check("bb_close_busy", busy, 1'b1);
    check("bb_close_d", lat_d, 8'h11);
    cyc();
    check("bb_gnt2", gnt, 4'b0100);
    check("bb_d2", lat_d, 8'hCC);
    check("bb_busy", busy, 1'b1);
    req = 4'b0000;
    cyc();
    check("bb_open2", lat_en, 4'b1000);
    drain("bb_drain");

    // Out-of-range address on the 3-word bank.
    set_rq(0, 2'd3, 8'h5A); req = 4'b0001;
    cyc();
    check("or_gnt", gnt3, 4'b0001);
    check("or_err_setup", err3, 1'b0);
    req = 4'b0000;
    cyc();
    check("or_err", err3, 1'b1);
    check("or_en", lat_en3, 3'b000);
    check("or_busy", busy3, 1'b1);
    check("or_main_err", err, 1'b0);
    check("or_main_en", lat_en, 4'b1000);
    cyc();
    check("or_err_pulse", err3, 1'b0);
    check("or_en2", lat_en3, 3'b000);
    cyc();
    check("or_close_busy", busy3, 1'b1);
    check("or_close_err", err3, 1'b0);
    cyc();
    check("or_idle", busy3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
